// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser: channel-voice state machine with running status.
// Emits one registered note event per complete Note On / Note Off message.
//
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   byte_valid    : byte_in carries a received byte this cycle
//   byte_in       : received MIDI byte
//   input_en      : one-cycle pulse, a note event is on the note outputs
//   note_in_en    : NOTE_ON / NOTE_OFF of the last event
//   note_in       : note number of the last event
//   velocity_in   : velocity of the last event
//   orphan_count  : saturating count of data bytes seen with no status

package midi_pkg;

  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_en_t;

endpackage

module midi_note_decoder
  import midi_pkg::*;
#(
  parameter int unsigned OMNI    = 1,
  parameter logic [3:0]  CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       input_en,
  output note_en_t   note_in_en,
  output logic [6:0] note_in,
  output logic [6:0] velocity_in,
  output logic [7:0] orphan_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] data1_q, data1_d;
  logic [7:0] orphan_q, orphan_d;
  logic       input_en_q, input_en_d;
  note_en_t   note_en_q, note_en_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;

  logic is_data;
  logic is_chan;
  logic is_sys;
  logic is_rt;
  logic one_data;
  logic note_msg;
  logic chan_ok;

  // Byte classes partition the full 0x00-0xFF range.
  assign is_data = ~byte_in[7];
  assign is_chan = byte_in[7] & (byte_in[7:4] != 4'hF);
  assign is_sys  = (byte_in[7:3] == 5'b11110);
  assign is_rt   = (byte_in[7:3] == 5'b11111);

  // 0xC0-0xDF carry a single data byte.
  assign one_data = (status_q[7:5] == 3'b110);
  // 0x8n / 0x9n are the only messages forwarded.
  assign note_msg = (status_q[7:5] == 3'b100);
  assign chan_ok  = (OMNI != 0) ||
                    (status_q[3:0] == CHANNEL);

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    data1_d    = data1_q;
    orphan_d   = orphan_q;
    input_en_d = 1'b0;
    note_en_d  = note_en_q;
    note_d     = note_q;
    vel_d      = vel_q;

    if (byte_valid) begin
      unique case (1'b1)
        is_chan: begin
          status_d = byte_in;
          state_d  = DATA1;
        end
        is_sys: begin
          status_d = 8'h00;
          state_d  = IDLE;
        end
        is_rt: begin
        end
        is_data: begin
          case (state_q)
            DATA1: begin
              if (!one_data) begin
                data1_d = byte_in[6:0];
                state_d = DATA2;
              end
            end
            DATA2: begin
              state_d = DATA1;
              if (note_msg && chan_ok) begin
                input_en_d = 1'b1;
                note_d     = data1_q;
                vel_d      = byte_in[6:0];
                // Note On with zero velocity is a Note Off.
                if (status_q[4] &&
                    (byte_in[6:0] != 7'd0))
                  note_en_d = NOTE_ON;
                else
                  note_en_d = NOTE_OFF;
              end
            end
            default: begin
              if (orphan_q != 8'hFF)
                orphan_d = orphan_q + 8'd1;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      status_q   <= 8'h00;
      data1_q    <= 7'd0;
      orphan_q   <= 8'd0;
      input_en_q <= 1'b0;
      note_en_q  <= NOTE_OFF;
      note_q     <= 7'd0;
      vel_q      <= 7'd0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      data1_q    <= data1_d;
      orphan_q   <= orphan_d;
      input_en_q <= input_en_d;
      note_en_q  <= note_en_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
    end
  end

  assign input_en     = input_en_q;
  assign note_in_en   = note_en_q;
  assign note_in      = note_q;
  assign velocity_in  = vel_q;
  assign orphan_count = orphan_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: an OMNI instance and a channel-2 instance
// share one byte stream and are compared against a message-level model.

module tb_midi_note_decoder;
  import midi_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_in = 8'h00;

  logic       en0, en1;
  note_en_t   ne0, ne1;
  logic [6:0] n0, n1, v0, v1;
  logic [7:0] o0, o1;

  always #5 clk = ~clk;

  midi_note_decoder #(.OMNI(1), .CHANNEL(4'd0)) u_omni (
    .clk(clk), .reset(reset),
    .byte_valid(byte_valid), .byte_in(byte_in),
    .input_en(en0), .note_in_en(ne0),
    .note_in(n0), .velocity_in(v0),
    .orphan_count(o0)
  );

  midi_note_decoder #(.OMNI(0), .CHANNEL(4'd2)) u_ch2 (
    .clk(clk), .reset(reset),
    .byte_valid(byte_valid), .byte_in(byte_in),
    .input_en(en1), .note_in_en(ne1),
    .note_in(n1), .velocity_in(v1),
    .orphan_count(o1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: running status (-1 = none) plus collected data bytes.
  int rs[2];
  int cnt[2];
  int d1[2];
  int e_en[2];
  int e_ne[2];
  int e_note[2];
  int e_vel[2];
  int e_orph[2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int m = 0; m < 2; m++) begin
      rs[m] = -1; cnt[m] = 0; d1[m] = 0;
      e_en[m] = 0; e_ne[m] = 0;
      e_note[m] = 0; e_vel[m] = 0; e_orph[m] = 0;
    end
  endfunction

  function automatic void m_byte(input int b);
    int len, hi;
    for (int m = 0; m < 2; m++) begin
      e_en[m] = 0;
      if (b >= 'hF8) begin
      end else if (b >= 'hF0) begin
        rs[m] = -1; cnt[m] = 0;
      end else if (b >= 'h80) begin
        rs[m] = b; cnt[m] = 0;
      end else if (rs[m] < 0) begin
        if (e_orph[m] < 255) e_orph[m]++;
      end else begin
        hi = rs[m] / 16;
        len = (hi == 12 || hi == 13) ? 1 : 2;
        if (cnt[m] == 0) d1[m] = b;
        cnt[m]++;
        if (cnt[m] == len) begin
          cnt[m] = 0;
          if ((hi == 8 || hi == 9) &&
              (m == 0 || rs[m] % 16 == 2)) begin
            e_en[m] = 1;
            e_note[m] = d1[m];
            e_vel[m] = b;
            e_ne[m] = (hi == 9 && b != 0) ? 1 : 0;
          end
        end
      end
    end
  endfunction

  task automatic check_all();
    chk("en0", 32'(en0), 32'(e_en[0]));
    chk("ne0", 32'(ne0), 32'(e_ne[0]));
    chk("note0", 32'(n0), 32'(e_note[0]));
    chk("vel0", 32'(v0), 32'(e_vel[0]));
    chk("orph0", 32'(o0), 32'(e_orph[0]));
    chk("en1", 32'(en1), 32'(e_en[1]));
    chk("ne1", 32'(ne1), 32'(e_ne[1]));
    chk("note1", 32'(n1), 32'(e_note[1]));
    chk("vel1", 32'(v1), 32'(e_vel[1]));
    chk("orph1", 32'(o1), 32'(e_orph[1]));
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in = b;
    @(posedge clk);
    #1;
    m_byte(int'(b));
    check_all();
    byte_valid = 1'b0;
  endtask

  task automatic idle();
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
    @(posedge clk);
    #1;
    e_en[0] = 0;
    e_en[1] = 0;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    byte_valid = 1'b0;
    m_reset();
    check_all();
  endtask

  logic [7:0] b;
  int r;

  initial begin
    do_reset();
    idle();

    send(8'h90); send(8'h3C); send(8'h64);
    chk("tp1_note", 32'(n0), 32'd60);
    idle();
    send(8'h90); send(8'h40); send(8'h50);
    send(8'h40); send(8'h00);
    chk("tp2_off", 32'(ne0), 32'(NOTE_OFF));
    send(8'h85); send(8'h41); send(8'h22);
    send(8'h90); send(8'hF8); send(8'h3C);
    send(8'hFE); send(8'h64);
    send(8'hC0); send(8'h05); send(8'h06);
    send(8'hB0); send(8'h07); send(8'h7F);
    send(8'h90); send(8'h3C);
    send(8'h80); send(8'h3D); send(8'h10);
    do_reset();
    send(8'hF0); send(8'h01); send(8'h02);
    send(8'hF7); send(8'h3C);
    chk("sysex_orph", 32'(o0), 32'd3);
    send(8'h91); send(8'h3C); send(8'h64);
    send(8'h92); send(8'h3C); send(8'h64);
    chk("ch2_en", 32'(en1), 32'd1);

    do_reset();
    repeat (300) send(8'($urandom_range(0, 127)));
    chk("orph_sat", 32'(o0), 32'd255);

    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    chk("rst_orph", 32'(o0), 32'd1);
    chk("rst_en", 32'(en0), 32'd0);

    repeat (3000) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        idle();
      end else if (r < 6) begin
        do_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 50)
          b = 8'($urandom_range(0, 127));
        else if (r < 75)
          b = {3'b100, 1'($urandom),
               4'($urandom_range(0, 3))};
        else if (r < 85)
          b = 8'($urandom_range(8'hA0, 8'hEF));
        else if (r < 92)
          b = 8'($urandom_range(8'hF0, 8'hF7));
        else
          b = 8'($urandom_range(8'hF8, 8'hFF));
        send(b);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/midi_note_decoder.md
Name: midi_note_decoder

Overview:
- Byte-stream MIDI parser that produces the note-event interface consumed by the polyphony controller: `input_en`, `note_in_en`, `note_in`, `velocity_in`.
- Sits between the UART receive path and polyphony control.
- Runs a channel-voice message state machine with running status.
- Emits one single-cycle event per complete Note On / Note Off message; all other traffic is dropped.

Parameters:
- OMNI, 1, when 1 accept all 16 channels; when 0 accept only CHANNEL.
- CHANNEL, 0, 4-bit MIDI channel (0-15) used when OMNI=0.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- byte_valid  input  1  byte_in is valid this cycle; every valid byte is accepted (no backpressure)
- byte_in  input  8  received MIDI byte
- input_en  output  1  one-cycle pulse: a note event is presented on the note outputs
- note_in_en  output  note_en_t  NOTE_ON or NOTE_OFF (conFFTi package type)
- note_in  output  7  note number
- velocity_in  output  7  velocity
- orphan_count  output  8  saturating count of data bytes discarded for lack of a status

Behaviour:
- Reset: input_en=0, note_in_en=NOTE_OFF, note_in=0, velocity_in=0, orphan_count=0, state=IDLE, running status cleared.
- Byte classes:
  - data: bit7=0.
  - channel status: 0x80-0xEF.
  - system common / sysex: 0xF0-0xF7.
  - real-time: 0xF8-0xFF.
- Real-time bytes: ignored completely; no change to state, running status or outputs. They may appear between any two bytes.
- States: IDLE (no valid running status), DATA1 (expecting first data byte), DATA2 (expecting second data byte).
- Channel status byte, accepted in any state: latch it as running status, go to DATA1, discard any partial message.
- 0xF0-0xF7: clear running status, go to IDLE. Sysex payload bytes then arriving in IDLE are counted as orphans.
- Data byte in IDLE: discarded, orphan_count += 1, saturating at 255.
- Data byte in DATA1:
  - status 0xC0-0xDF (one-data-byte messages): message complete and dropped; stay in DATA1 (running status).
  - otherwise: latch data1, go to DATA2.
- Data byte in DATA2: message complete, return to DATA1 (running status retained).
  - If status high nibble is 0x8 or 0x9 and the channel matches (OMNI=1, or status[3:0]==CHANNEL), emit an event.
  - 0xA0, 0xB0, 0xE0 messages and non-matching channels are parsed for length but not emitted.
- Event generation (registered):
  - input_en=1 on the cycle after the completing byte is accepted (latency 1), for exactly one cycle.
  - note_in=data1, velocity_in=data2.
  - note_in_en=NOTE_ON if status is 0x9n and velocity!=0; NOTE_OFF for 0x8n, and for 0x9n with velocity 0.
- note_in_en, note_in and velocity_in hold their last values between events; input_en is 0 otherwise.
- byte_valid=0: no state change; input_en returns to 0.
- Back-to-back valid bytes every cycle are supported: one event per completed message, events may be 2 cycles apart under running status.
- reset asserted mid-message: partial message and running status discarded; next data byte counts as an orphan.

Test Plan:
- Stream 0x90,0x3C,0x64 on consecutive cycles → one cycle after the third byte: input_en=1, NOTE_ON, note_in=60, velocity_in=100; input_en=0 the following cycle.
- Running status 0x90,0x40,0x50,0x40,0x00 → two events: (NOTE_ON, 64, 80), then (NOTE_OFF, 64, 0); then 0x85,0x41,0x22 → (NOTE_OFF, 65, 34).
- Real-time and drops: 0x90,0xF8,0x3C,0xFE,0x64 → single NOTE_ON 60/100. Also 0xC0,0x05,0x06 → no events, orphan_count unchanged. Also 0xB0,0x07,0x7F → no event.
- Interruption: 0x90,0x3C then 0x80,0x3D,0x10 → only NOTE_OFF 61/16 emitted. Also 0xF0,0x01,0x02,0xF7,0x3C → no event, orphan_count=3.
- Channel filter, OMNI=0, CHANNEL=2: 0x91,0x3C,0x64 → no event; 0x92,0x3C,0x64 → NOTE_ON 60/100.
- Reset and saturation: 300 data bytes after reset → orphan_count=255. reset between 0x90,0x3C and 0x64 → no event, orphan_count=1, all outputs at reset values.
